led_pattern_engine: RTL and testbench

- Parametrised successor to the team's fixed 8-bit LED rotator.
- Drives a WIDTH-bit LED bank with a selectable animation:
  - rotate left
  - rotate right
  - bounce (ping-pong)
  - Johnson fill/drain
- Step rate comes from an internal prescaler with runtime speed select, pause (enable) and synchronous pattern load.
- Sits between board I/O (switches/buttons, already synchronised upstream) and the LED pins.

---
 rtl/led_pkg.sv | 14 +
 rtl/led_tick_gen.sv | 41 ++++
 rtl/led_pattern_engine.sv | 82 ++++++++
 tb/tb_led_pattern_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern engine: animation modes and bounce direction.
package led_pkg;

    localparam logic [1:0] MODE_ROT_L   = 2'b00;
    localparam logic [1:0] MODE_ROT_R   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: emits a one-cycle tick every max(TICK_DIV >> speed_sel, 1) enabled cycles.
module led_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] speed_sel,
    output logic       tick
);

    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] DIV = CW'(TICK_DIV);

    logic [CW-1:0] count;
    logic [CW-1:0] shifted;
    logic [CW-1:0] period;
    logic          wrap;

    // Using >= rather than == lets a mid-count speed-up wrap on the very next edge.
    always_comb begin
        shifted = DIV >> speed_sel;
        period  = (shifted == '0) ? CW'(1) : shifted;
        wrap    = (count >= period - CW'(1));
    end

    assign tick = enable && !clear && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (wrap) count <= '0;
            else      count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// WIDTH-bit LED animator: rotate left/right, bounce and Johnson fill/drain,
// stepped by led_tick_gen, with pause and a synchronous pattern load that overrides stepping.
module led_pattern_engine #(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = 25_000_000,
    parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'('h1F)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed_sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] leds,
    output logic             step_pulse
);

    import led_pkg::*;

    logic             tick;
    dir_t             dir;
    dir_t             next_dir;
    logic [WIDTH-1:0] next_leds;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (load),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

    assign rot_l = {leds[WIDTH-2:0], leds[WIDTH-1]};
    assign rot_r = {leds[0], leds[WIDTH-1:1]};

    // Bounce looks at the pre-step value so the end LED is shown once before reversing.
    always_comb begin
        next_leds = leds;
        next_dir  = DIR_LEFT;
        case (mode)
            MODE_ROT_L: next_leds = rot_l;
            MODE_ROT_R: next_leds = rot_r;
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT && leds[WIDTH-1]) begin
                    next_dir  = DIR_RIGHT;
                    next_leds = rot_r;
                end else if (dir == DIR_RIGHT && leds[0]) begin
                    next_dir  = DIR_LEFT;
                    next_leds = rot_l;
                end else begin
                    next_dir  = dir;
                    next_leds = (dir == DIR_LEFT) ? rot_l : rot_r;
                end
            end
            default: next_leds = {leds[WIDTH-2:0], ~leds[WIDTH-1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds       <= INIT_PATTERN;
            dir        <= DIR_LEFT;
            step_pulse <= 1'b0;
        end else if (load) begin
            leds       <= load_data;
            dir        <= DIR_LEFT;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= tick;
            if (tick) leds <= next_leds;
            if (mode != MODE_BOUNCE) dir <= DIR_LEFT;
            else if (tick)           dir <= next_dir;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine (WIDTH=8, TICK_DIV=4, INIT_PATTERN=0x1F).
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [1:0] speed_sel;
    logic       load;
    logic [7:0] load_data;
    logic [7:0] leds;
    logic       step_pulse;

    int checks = 0;
    int passed = 0;

    led_pattern_engine #(
        .WIDTH        (8),
        .TICK_DIV     (4),
        .INIT_PATTERN (8'h1F)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .speed_sel  (speed_sel),
        .load       (load),
        .load_data  (load_data),
        .leds       (leds),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge, outputs are sampled at the same point.
    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] value, input logic [1:0] new_mode, input logic [1:0] new_speed);
        load      = 1'b1;
        load_data = value;
        mode      = new_mode;
        speed_sel = new_speed;
        tick_edge();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        mode      = 2'b00;
        speed_sel = 2'd0;
        load      = 1'b0;
        load_data = 8'h00;
        repeat (2) tick_edge();
        checks++;
        if (leds !== 8'h1F) $display("[TB] FAIL reset_leds: got %h expected 1f", leds);
        else passed++;
        checks++;
        if (step_pulse !== 1'b0) $display("[TB] FAIL reset_pulse: got %b expected 0", step_pulse);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_rot_left();
        logic [7:0] seq [4];
        logic [7:0] prev;
        seq  = '{8'h3E, 8'h7C, 8'hF8, 8'hF1};
        prev = 8'h1F;
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= 4; c++) begin
                tick_edge();
                checks++;
                if (c < 4) begin
                    if (leds !== prev || step_pulse !== 1'b0)
                        $display("[TB] FAIL rotl_hold step%0d cyc%0d: got %h/%b expected %h/0", k, c, leds, step_pulse, prev);
                    else passed++;
                end else begin
                    if (leds !== seq[k] || step_pulse !== 1'b1)
                        $display("[TB] FAIL rotl_step %0d: got %h/%b expected %h/1", k, leds, step_pulse, seq[k]);
                    else passed++;
                end
            end
            prev = seq[k];
        end
    endtask

    task automatic test_rot_right_speed();
        logic [7:0] slow [2];
        logic [7:0] fast [6];
        slow = '{8'h8F, 8'hC7};
        fast = '{8'hE3, 8'hF1, 8'hF8, 8'h7C, 8'h3E, 8'h1F};
        do_load(8'h1F, 2'b01, 2'd0);
        for (int k = 0; k < 2; k++) begin
            repeat (4) tick_edge();
            checks++;
            if (leds !== slow[k] || step_pulse !== 1'b1)
                $display("[TB] FAIL rotr_slow %0d: got %h/%b expected %h/1", k, leds, step_pulse, slow[k]);
            else passed++;
        end
        for (int k = 0; k < 6; k++) begin
            speed_sel = (k < 4) ? 2'd2 : 2'd3;
            tick_edge();
            checks++;
            if (leds !== fast[k] || step_pulse !== 1'b1)
                $display("[TB] FAIL rotr_fast %0d: got %h/%b expected %h/1", k, leds, step_pulse, fast[k]);
            else passed++;
        end
        speed_sel = 2'd0;
        repeat (2) tick_edge();
        checks++;
        if (leds !== 8'h1F || step_pulse !== 1'b0)
            $display("[TB] FAIL speedup_pre: got %h/%b expected 1f/0", leds, step_pulse);
        else passed++;
        speed_sel = 2'd2;
        tick_edge();
        checks++;
        if (leds !== 8'h8F || step_pulse !== 1'b1)
            $display("[TB] FAIL speedup_step: got %h/%b expected 8f/1", leds, step_pulse);
        else passed++;
        speed_sel = 2'd0;
    endtask

    task automatic test_bounce();
        logic [7:0] seq [15];
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        do_load(8'h01, 2'b10, 2'd2);
        for (int k = 0; k < 15; k++) begin
            tick_edge();
            checks++;
            if (leds !== seq[k] || step_pulse !== 1'b1)
                $display("[TB] FAIL bounce %0d: got %h/%b expected %h/1", k, leds, step_pulse, seq[k]);
            else passed++;
        end
    endtask

    task automatic test_johnson();
        logic [7:0] seq [17];
        seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
        do_load(8'h00, 2'b11, 2'd2);
        for (int k = 0; k < 17; k++) begin
            tick_edge();
            checks++;
            if (leds !== seq[k] || step_pulse !== 1'b1)
                $display("[TB] FAIL johnson %0d: got %h/%b expected %h/1", k, leds, step_pulse, seq[k]);
            else passed++;
        end
    endtask

    task automatic test_enable_load();
        do_load(8'h01, 2'b00, 2'd0);
        repeat (2) tick_edge();
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick_edge();
            checks++;
            if (leds !== 8'h01 || step_pulse !== 1'b0)
                $display("[TB] FAIL paused %0d: got %h/%b expected 01/0", c, leds, step_pulse);
            else passed++;
        end
        enable = 1'b1;
        tick_edge();
        checks++;
        if (leds !== 8'h01 || step_pulse !== 1'b0)
            $display("[TB] FAIL resume_hold: got %h/%b expected 01/0", leds, step_pulse);
        else passed++;
        tick_edge();
        checks++;
        if (leds !== 8'h02 || step_pulse !== 1'b1)
            $display("[TB] FAIL resume_step: got %h/%b expected 02/1", leds, step_pulse);
        else passed++;
        repeat (3) tick_edge();
        do_load(8'hA5, 2'b00, 2'd0);
        checks++;
        if (leds !== 8'hA5 || step_pulse !== 1'b0)
            $display("[TB] FAIL load_prio: got %h/%b expected a5/0", leds, step_pulse);
        else passed++;
        for (int c = 1; c <= 4; c++) begin
            tick_edge();
            checks++;
            if (c < 4) begin
                if (leds !== 8'hA5 || step_pulse !== 1'b0)
                    $display("[TB] FAIL post_load_hold %0d: got %h/%b expected a5/0", c, leds, step_pulse);
                else passed++;
            end else begin
                if (leds !== 8'h4B || step_pulse !== 1'b1)
                    $display("[TB] FAIL post_load_step: got %h/%b expected 4b/1", leds, step_pulse);
                else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_load(8'h3E, 2'b00, 2'd2);
        tick_edge();
        checks++;
        if (leds !== 8'h7C || step_pulse !== 1'b1)
            $display("[TB] FAIL prereset_state: got %h/%b expected 7c/1", leds, step_pulse);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (leds !== 8'h1F || step_pulse !== 1'b0)
            $display("[TB] FAIL async_reset: got %h/%b expected 1f/0", leds, step_pulse);
        else passed++;
        tick_edge();
        speed_sel = 2'd0;
        rst_n     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick_edge();
            checks++;
            if (c < 4) begin
                if (leds !== 8'h1F || step_pulse !== 1'b0)
                    $display("[TB] FAIL post_reset_hold %0d: got %h/%b expected 1f/0", c, leds, step_pulse);
                else passed++;
            end else begin
                if (leds !== 8'h3E || step_pulse !== 1'b1)
                    $display("[TB] FAIL post_reset_step: got %h/%b expected 3e/1", leds, step_pulse);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rot_left();
        test_rot_right_speed();
        test_bounce();
        test_johnson();
        test_enable_load();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
